instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of control_unit_top and the datapath.

---
 rtl/instr_fetch_unit_pkg.sv | 42 ++++
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, RV32 field positions, opcodes and the buffered entry type.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OP_LSB     = 0;
    localparam int unsigned OP_W       = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

    localparam logic [OP_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OP_W-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OP_W-1:0] OPC_AUIPC  = 7'h17;
    localparam logic [OP_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OP_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OP_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OP_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OP_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OP_W-1:0] OPC_JAL    = 7'h6f;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [OP_W-1:0] instr_op(input logic [ILEN-1:0] instr);
        return instr[OP_LSB +: OP_W];
    endfunction

    function automatic logic [FUNCT3_W-1:0] instr_funct3(input logic [ILEN-1:0] instr);
        return instr[FUNCT3_LSB +: FUNCT3_W];
    endfunction

    function automatic logic [FUNCT7_W-1:0] instr_funct7(input logic [ILEN-1:0] instr);
        return instr[FUNCT7_LSB +: FUNCT7_W];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from execute, decode slot.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               op, funct3, funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               op, funct3, funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous instruction buffer with flush; flush outranks push/pop, no read-through bypass.
module instr_fetch_unit_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem requests, buffers words for decode,
// and squashes buffered/in-flight words on a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full, fifo_empty;
    logic            credit_c, req_valid_c, req_fire_c, push_c, pop_c;
    logic [XLEN-1:0] target_c;
    logic            unused_c;
    fetch_entry_t    head, push_entry;

    assign target_c = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_c = ^bus.redirect_pc[1:0];

    // Requests in flight plus buffered words never exceed the buffer, so every response has a slot.
    assign credit_c    = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
    assign req_valid_c = !rst && !bus.redirect && credit_c && (drop_q == '0);
    assign req_fire_c  = req_valid_c && bus.imem_req_ready;
    assign pop_c       = bus.id_valid && bus.id_ready && !bus.redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        push_c     = 1'b0;
        if (bus.redirect) begin
            fetch_pc_d = target_c;
            rsp_pc_d   = target_c;
            outst_d    = outst_q - CW'(bus.imem_rsp_valid);
            drop_d     = outst_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire_c) fetch_pc_d = fetch_pc_q + XLEN'(4);
            outst_d = outst_q + CW'(req_fire_c) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push_c   = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push_c && fifo_full));
    end

    assign push_entry.instr = bus.imem_rsp_data;
    assign push_entry.pc    = rsp_pc_q;

    instr_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (bus.redirect),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = !rst && !fifo_empty;
    assign bus.id_instr       = head.instr;
    assign bus.id_pc          = head.pc;
    assign bus.id_pc_plus4    = head.pc + XLEN'(4);
    assign bus.op             = instr_op(head.instr);
    assign bus.funct3         = instr_funct3(head.instr);
    assign bus.funct7         = instr_funct7(head.instr);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order variable-latency memory model and a decode monitor.
module tb_instr_fetch_unit;
    localparam int unsigned FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   lat = 1;
    logic mem_stall = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int   n_pop = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h200) return 32'h0020_81B3;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic wait_id(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #4;
            if (bus.id_valid) break;
        end
        check_eq(tag, 64'(bus.id_valid), 64'd1);
    endtask

    // Memory: response decided at +1 after negedge, request acceptance sampled at +2.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_req_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                bus.imem_rsp_valid = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
            bus.imem_req_ready = !mem_stall;
            #1;
            if (bus.imem_req_valid && bus.imem_req_ready)
                mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        end
    end

    // Decode monitor: every consumed word must be the next sequential address with its memory contents.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                exp_pc = 32'h0;
            end else if (bus.redirect) begin
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end else if (bus.id_valid && bus.id_ready) begin
                check_eq("dec_pc", 64'(bus.id_pc), 64'(exp_pc));
                check_eq("dec_instr", 64'(bus.id_instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  p0;
        logic hit;
        rst              = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.id_ready     = 1'b1;

        // Reset state
        repeat (2) begin
            @(negedge clk); #4;
            check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            check_eq("rst_id_valid", 64'(bus.id_valid), 64'd0);
        end

        // Sequential fetch, 1-cycle memory
        @(negedge clk); rst = 1'b0; #4;
        check_eq("t1_req_valid0", 64'(bus.imem_req_valid), 64'd1);
        check_eq("t1_req_addr0", 64'(bus.imem_req_addr), 64'h0);
        @(negedge clk); #4;
        check_eq("t1_req_addr1", 64'(bus.imem_req_addr), 64'h4);
        @(negedge clk); #4;
        check_eq("t1_id_valid", 64'(bus.id_valid), 64'd1);
        check_eq("t1_id_pc", 64'(bus.id_pc), 64'h0);
        check_eq("t1_id_pc_plus4", 64'(bus.id_pc_plus4), 64'h4);
        check_eq("t1_credit_stop", 64'(bus.imem_req_valid), 64'd0);
        repeat (8) @(negedge clk);

        // Decode stall: buffer fills, requests stop, head stays put
        @(negedge clk); bus.id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #4;
            if (i >= 3) begin
                check_eq("t2_id_valid", 64'(bus.id_valid), 64'd1);
                check_eq("t2_id_pc", 64'(bus.id_pc), 64'(exp_pc));
                check_eq("t2_id_instr", 64'(bus.id_instr), 64'(mem_word(exp_pc)));
                check_eq("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
            end
            @(negedge clk);
        end
        bus.id_ready = 1'b1;
        mem_stall    = 1'b1;
        p0           = n_pop;
        repeat (5) @(negedge clk);
        #4;
        check_eq("t2_buffered_words", 64'(n_pop - p0), 64'(FIFO_DEPTH));

        // Memory stall holds the request; redirect during stall retargets it
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #4;
            check_eq("t5_req_valid", 64'(bus.imem_req_valid), 64'd1);
            check_eq("t5_req_addr", 64'(bus.imem_req_addr), 64'(exp_pc));
        end
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'h300; #4;
        check_eq("t5_redir_withdraw", 64'(bus.imem_req_valid), 64'd0);
        @(negedge clk); bus.redirect = 1'b0; #4;
        check_eq("t5_redir_addr", 64'(bus.imem_req_addr), 64'h300);
        check_eq("t5_redir_valid", 64'(bus.imem_req_valid), 64'd1);

        // 3-cycle memory, redirect with two requests in flight
        lat = 3;
        @(negedge clk); mem_stall = 1'b0; #4;
        check_eq("t3_req_addr0", 64'(bus.imem_req_addr), 64'h300);
        @(negedge clk); #4;
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'h100; #4;
        check_eq("t3_inflight", 64'(mq.size()), 64'd2);
        check_eq("t3_redir_withdraw", 64'(bus.imem_req_valid), 64'd0);
        @(negedge clk); bus.redirect = 1'b0; #4;
        check_eq("t3_drop_hold0", 64'(bus.imem_req_valid), 64'd0);
        @(negedge clk); #4;
        check_eq("t3_drop_hold1", 64'(bus.imem_req_valid), 64'd0);
        @(negedge clk); #4;
        check_eq("t3_restart_valid", 64'(bus.imem_req_valid), 64'd1);
        check_eq("t3_restart_addr", 64'(bus.imem_req_addr), 64'h100);
        wait_id("t3_id_timeout", 20);
        check_eq("t3_first_pc", 64'(bus.id_pc), 64'h100);

        // Misaligned target and redirect coinciding with a response
        lat = 1;
        repeat (10) @(negedge clk);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
                hit = 1'b1;
                bus.redirect = 1'b1;
                bus.redirect_pc = 32'h103;
            end
            #4;
        end
        check_eq("t4_found_rsp", 64'(hit), 64'd1);
        @(negedge clk); bus.redirect = 1'b0; #4;
        check_eq("t4_aligned_addr", 64'(bus.imem_req_addr), 64'h100);
        check_eq("t4_req_valid", 64'(bus.imem_req_valid), 64'd1);
        wait_id("t4_id_timeout", 20);
        check_eq("t4_first_pc", 64'(bus.id_pc), 64'h100);

        // Field slicing of add x3,x1,x2
        @(negedge clk); bus.id_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        @(negedge clk); bus.redirect = 1'b0;
        wait_id("t6_id_timeout", 20);
        check_eq("t6_id_pc", 64'(bus.id_pc), 64'h200);
        check_eq("t6_instr", 64'(bus.id_instr), 64'h0020_81B3);
        check_eq("t6_op", 64'(bus.op), 64'h33);
        check_eq("t6_funct3", 64'(bus.funct3), 64'h0);
        check_eq("t6_funct7", 64'(bus.funct7), 64'h00);

        // Reset mid-stream with a full buffer
        repeat (3) @(negedge clk);
        rst = 1'b1; #4;
        check_eq("t6_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check_eq("t6_rst_id_valid", 64'(bus.id_valid), 64'd0);
        @(negedge clk); rst = 1'b0; #4;
        check_eq("t6_post_rst_id_valid", 64'(bus.id_valid), 64'd0);
        check_eq("t6_post_rst_addr", 64'(bus.imem_req_addr), 64'h0);
        check_eq("t6_post_rst_valid", 64'(bus.imem_req_valid), 64'd1);
        bus.id_ready = 1'b1;
        wait_id("t6_restart_timeout", 20);
        check_eq("t6_restart_pc", 64'(bus.id_pc), 64'h0);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
